// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: read-back monitor for a multiplexed seven-segment scan bus.
// Decodes each strobed digit pattern to BCD and commits a digit only after it
// has been seen STABLE_COUNT times in a row. It also flags frame completion and
// non-one-hot digit selects.
// Optional feature macro: SEG7_DP_EN adds a decimal-point bit (scan_seg[7]) and
// the dp_out port.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned STABLE_COUNT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_strobe,
`ifdef SEG7_DP_EN
  input  logic [7:0]              scan_seg,
`else
  input  logic [6:0]              scan_seg,
`endif
  input  logic [NUM_DIGITS-1:0]   scan_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    sel_err
`ifdef SEG7_DP_EN
  ,
  output logic [NUM_DIGITS-1:0]   dp_out
`endif
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_COUNT);
  localparam logic [3:0] BLANK      = 4'hF;

  logic [NUM_DIGITS-1:0][3:0] cand_q, cand_d;
  logic [NUM_DIGITS-1:0][3:0] cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]      valid_q, valid_d;
  logic [NUM_DIGITS-1:0]      seen_q, seen_d;
  logic                       frame_q, frame_d;
  logic                       sel_err_q, sel_err_d;
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]      cdp_q, cdp_d;
  logic [NUM_DIGITS-1:0]      dp_q, dp_d;
`endif

  logic [3:0] code_c;
  logic       sel_legal_c;
  logic       match_c;

  // Segment pattern to BCD code; anything unrecognised reads as blank.
  always_comb begin
    code_c = BLANK;
    case (scan_seg[6:0])
      7'b1111110: code_c = 4'd0;
      7'b0110000: code_c = 4'd1;
      7'b1101101: code_c = 4'd2;
      7'b1111001: code_c = 4'd3;
      7'b0110011: code_c = 4'd4;
      7'b1011011: code_c = 4'd5;
      7'b1011111: code_c = 4'd6;
      7'b1110000: code_c = 4'd7;
      7'b1111111: code_c = 4'd8;
      7'b1111011: code_c = 4'd9;
      default:    code_c = BLANK;
    endcase
  end

  // Exactly one select bit may be set on a strobe.
  assign sel_legal_c = (scan_sel != '0) &&
                       ((scan_sel & (scan_sel - NUM_DIGITS'(1))) == '0);

  // Per-digit stability tracking, commit and frame bookkeeping.
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    frame_d   = 1'b0;
    sel_err_d = 1'b0;
    match_c   = 1'b0;
`ifdef SEG7_DP_EN
    cdp_d     = cdp_q;
    dp_d      = dp_q;
`endif
    if (scan_strobe) begin
      if (sel_legal_c) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (scan_sel[i]) begin
`ifdef SEG7_DP_EN
            match_c = (code_c == cand_q[i]) && (scan_seg[7] == cdp_q[i]);
`else
            match_c = (code_c == cand_q[i]);
`endif
            if (match_c) begin
              cnt_d[i] = (cnt_q[i] >= STABLE_MAX) ? STABLE_MAX : cnt_q[i] + 4'd1;
            end else begin
              cand_d[i] = code_c;
              cnt_d[i]  = 4'd1;
`ifdef SEG7_DP_EN
              cdp_d[i]  = scan_seg[7];
`endif
            end
            if (cnt_d[i] == STABLE_MAX) begin
              bcd_d[i]   = cand_d[i];
              valid_d[i] = (cand_d[i] != BLANK);
`ifdef SEG7_DP_EN
              dp_d[i]    = cdp_d[i];
`endif
            end
            seen_d[i] = 1'b1;
          end
        end
        // The completing strobe does not count toward the next frame.
        if (&seen_d) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end
      end else begin
        sel_err_d = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q    <= {NUM_DIGITS{BLANK}};
      cnt_q     <= '0;
      bcd_q     <= {NUM_DIGITS{BLANK}};
      valid_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      sel_err_q <= 1'b0;
`ifdef SEG7_DP_EN
      cdp_q     <= '0;
      dp_q      <= '0;
`endif
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      sel_err_q <= sel_err_d;
`ifdef SEG7_DP_EN
      cdp_q     <= cdp_d;
      dp_q      <= dp_d;
`endif
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign sel_err     = sel_err_q;
`ifdef SEG7_DP_EN
  assign dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (default build, 6 digits,
// STABLE_COUNT = 2).
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst;
  logic        scan_strobe;
`ifdef SEG7_DP_EN
  logic [7:0]  scan_seg;
  logic [5:0]  dp_out;
`else
  logic [6:0]  scan_seg;
`endif
  logic [5:0]  scan_sel;
  logic [23:0] bcd_out;
  logic [5:0]  digit_valid;
  logic        frame_done;
  logic        sel_err;

  int pass_cnt;
  int total_cnt;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_X = 7'b0000000;

  seg7_scan_decoder #(.NUM_DIGITS(6), .STABLE_COUNT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_strobe (scan_strobe),
    .scan_seg    (scan_seg),
    .scan_sel    (scan_sel),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .sel_err     (sel_err)
`ifdef SEG7_DP_EN
    ,
    .dp_out      (dp_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One strobe: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic strobe(input logic [5:0] sel, input logic [6:0] seg);
    @(negedge clk);
    scan_strobe = 1'b1;
    scan_sel    = sel;
`ifdef SEG7_DP_EN
    scan_seg    = {1'b0, seg};
`else
    scan_seg    = seg;
`endif
    @(posedge clk);
    #1;
    scan_strobe = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bcd_out !== 24'hFFFFFF) $display("FAIL reset_bcd: got %h expected ffffff", bcd_out);
    else pass_cnt++;
    total_cnt++;
    if (digit_valid !== 6'h00) $display("FAIL reset_valid: got %h expected 00", digit_valid);
    else pass_cnt++;
    total_cnt++;
    if ({frame_done, sel_err} !== 2'b00) $display("FAIL reset_pulses: got %b expected 00", {frame_done, sel_err});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stability();
    strobe(6'b000001, SEG_5);
    total_cnt++;
    if (bcd_out[3:0] !== 4'hF) $display("FAIL stab_s1: got %h expected f", bcd_out[3:0]);
    else pass_cnt++;
    strobe(6'b000001, SEG_3);
    total_cnt++;
    if ({digit_valid[0], bcd_out[3:0]} !== 5'h0F) $display("FAIL stab_s2: got %h expected 0f", {digit_valid[0], bcd_out[3:0]});
    else pass_cnt++;
    strobe(6'b000001, SEG_3);
    total_cnt++;
    if ({digit_valid[0], bcd_out[3:0]} !== 5'h13) $display("FAIL stab_s3: got %h expected 13", {digit_valid[0], bcd_out[3:0]});
    else pass_cnt++;
  endtask

  task automatic test_invalid();
    strobe(6'b000100, SEG_7);
    strobe(6'b000100, SEG_7);
    total_cnt++;
    if ({digit_valid[2], bcd_out[11:8]} !== 5'h17) $display("FAIL inv_hold7: got %h expected 17", {digit_valid[2], bcd_out[11:8]});
    else pass_cnt++;
    strobe(6'b000100, SEG_X);
    total_cnt++;
    if ({digit_valid[2], bcd_out[11:8]} !== 5'h17) $display("FAIL inv_first_blank: got %h expected 17", {digit_valid[2], bcd_out[11:8]});
    else pass_cnt++;
    strobe(6'b000100, SEG_X);
    total_cnt++;
    if ({digit_valid[2], bcd_out[11:8]} !== 5'h0F) $display("FAIL inv_commit_blank: got %h expected 0f", {digit_valid[2], bcd_out[11:8]});
    else pass_cnt++;
  endtask

  task automatic test_frame();
    logic [5:0] order2 [6];
    order2 = '{6'b100000, 6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000};
    for (int i = 0; i < 6; i++) begin
      strobe(6'(1 << i), SEG_8);
      total_cnt++;
      if (frame_done !== (i == 5)) $display("FAIL frame_a%0d: got %b expected %b", i, frame_done, (i == 5));
      else pass_cnt++;
    end
    idle_cycle();
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL frame_pulse_width: got %b expected 0", frame_done);
    else pass_cnt++;
    // Digit 5 twice first, then the remaining five; pulse only on the last.
    strobe(6'b100000, SEG_8);
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL frame_b_first: got %b expected 0", frame_done);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      strobe(order2[i], SEG_8);
      total_cnt++;
      if (frame_done !== (i == 5)) $display("FAIL frame_b%0d: got %b expected %b", i, frame_done, (i == 5));
      else pass_cnt++;
    end
    total_cnt++;
    if ({digit_valid, bcd_out} !== {6'h3F, 24'h888888}) $display("FAIL frame_all8: got %h %h expected 3f 888888", digit_valid, bcd_out);
    else pass_cnt++;
  endtask

  task automatic test_sel_err();
    strobe(6'b000011, SEG_0);
    total_cnt++;
    if ({sel_err, bcd_out} !== {1'b1, 24'h888888}) $display("FAIL selerr_two: got %b %h expected 1 888888", sel_err, bcd_out);
    else pass_cnt++;
    idle_cycle();
    total_cnt++;
    if (sel_err !== 1'b0) $display("FAIL selerr_once: got %b expected 0", sel_err);
    else pass_cnt++;
    strobe(6'b000000, SEG_0);
    total_cnt++;
    if ({sel_err, bcd_out} !== {1'b1, 24'h888888}) $display("FAIL selerr_zero: got %b %h expected 1 888888", sel_err, bcd_out);
    else pass_cnt++;
    // A legal strobe right after the error clears the pulse and starts a new candidate.
    strobe(6'b000001, SEG_0);
    total_cnt++;
    if ({sel_err, bcd_out[3:0]} !== 5'h08) $display("FAIL selerr_after: got %h expected 08", {sel_err, bcd_out[3:0]});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    strobe(6'b000010, SEG_2);
    total_cnt++;
    if (bcd_out[7:4] !== 4'h8) $display("FAIL b2b_first: got %h expected 8", bcd_out[7:4]);
    else pass_cnt++;
    strobe(6'b000010, SEG_2);
    total_cnt++;
    if (bcd_out[7:4] !== 4'h2) $display("FAIL b2b_second: got %h expected 2", bcd_out[7:4]);
    else pass_cnt++;
    // Interleaved digits do not disturb each other's stability count.
    strobe(6'b001000, SEG_4);
    strobe(6'b010000, SEG_9);
    strobe(6'b001000, SEG_4);
    total_cnt++;
    if (bcd_out !== 24'h884828) $display("FAIL b2b_interleave: got %h expected 884828", bcd_out);
    else pass_cnt++;
    strobe(6'b010000, SEG_9);
    total_cnt++;
    if (bcd_out !== 24'h894828) $display("FAIL b2b_second_digit: got %h expected 894828", bcd_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    strobe(6'b000001, SEG_1);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({digit_valid, bcd_out} !== {6'h00, 24'hFFFFFF}) $display("FAIL rstmid_async: got %h %h expected 00 ffffff", digit_valid, bcd_out);
    else pass_cnt++;
    idle_cycle();
    total_cnt++;
    if ({frame_done, sel_err} !== 2'b00) $display("FAIL rstmid_pulses: got %b expected 00", {frame_done, sel_err});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    strobe(6'b000001, SEG_1);
    total_cnt++;
    if (bcd_out[3:0] !== 4'hF) $display("FAIL rstmid_s1: got %h expected f", bcd_out[3:0]);
    else pass_cnt++;
    strobe(6'b000001, SEG_1);
    total_cnt++;
    if ({digit_valid, bcd_out} !== {6'h01, 24'hFFFFF1}) $display("FAIL rstmid_s2: got %h %h expected 01 fffff1", digit_valid, bcd_out);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    rst         = 1'b1;
    scan_strobe = 1'b0;
    scan_sel    = '0;
    scan_seg    = '0;
    test_reset();
    test_stability();
    test_invalid();
    test_frame();
    test_sel_err();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

- Recovers BCD digits from a multiplexed seven-segment scan bus: the segment pattern plus a one-hot digit-select, as driven to the clock's display.
- Sits on the display side of the clock as a read-back monitor. It decodes each digit's pattern back to 0–9 and filters glitches with a per-digit stability counter.
- It publishes registered BCD values, per-digit valid flags and a frame-complete pulse, for self-check and for the time-setting logic.

## Interface
Parameters:
- NUM_DIGITS, 6, number of scanned digits (HH:MM:SS); range 1..8.
- STABLE_COUNT, 2, consecutive identical samples required before a digit commits; range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- scan_strobe  input  1  segment and digit-select inputs are valid this cycle.
- scan_seg  input  7 (8 with SEG7_DP_EN)  segment pattern. Bit 6 = a … bit 0 = g, active-high. Bit 7 = dp when configured.
- scan_sel  input  NUM_DIGITS  one-hot digit select; bit i = digit i (0 = least significant).
- bcd_out  output  4*NUM_DIGITS  committed digits; nibble i = digit i; 4'hF = invalid/blank.
- digit_valid  output  NUM_DIGITS  bit i high when nibble i holds a decoded 0–9.
- frame_done  output  1  one-cycle pulse when every digit has been sampled since the last pulse.
- sel_err  output  1  one-cycle pulse when a strobe carries a non-one-hot scan_sel.
- dp_out  output  NUM_DIGITS  committed decimal points (only with SEG7_DP_EN).

## Operation
- Decode table, scan_seg[6:0] → code:
  - 1111110 → 0, 0110000 → 1, 1101101 → 2, 1111001 → 3, 0110011 → 4
  - 1011011 → 5, 1011111 → 6, 1110000 → 7, 1111111 → 8, 1111011 → 9
  - any other pattern, including 0000000 → 4'hF.
- Per-digit state: candidate[3:0], stab_cnt[3:0], committed nibble, valid bit.
- On a strobe with a legal one-hot scan_sel = bit i:
  - If code == candidate[i]: stab_cnt[i] increments, saturating at STABLE_COUNT.
  - Otherwise: candidate[i] ← code and stab_cnt[i] ← 1.
  - When the updated stab_cnt[i] == STABLE_COUNT, commit: nibble i ← candidate and digit_valid[i] ← (candidate != 4'hF).
  - Commit re-occurs on every further matching strobe; the values are unchanged.
  - seen[i] ← 1.
- On a strobe with an illegal scan_sel (zero or more than one bit set):
  - No digit state changes.
  - sel_err pulses next cycle.
- No strobe: all state holds.
- Frame:
  - When seen becomes all-ones, frame_done pulses next cycle and seen clears to zero.
  - The completing strobe's bit is not carried into the new frame.
- Digits not strobed keep their committed values indefinitely; there is no timeout.
- STABLE_COUNT = 1: every legal strobe commits immediately.

## Timing
- All outputs are registered. Strobe at edge N → visible after edge N+1.
- Commit latency: STABLE_COUNT matching strobes on a digit; the output updates one cycle after the last of them. Strobes for other digits may interleave without resetting the count.
- Back-to-back strobes every cycle are supported; there are no bubbles.
- Reset, asynchronous and immediate, also valid mid-frame:
  - bcd_out = all 4'hF, digit_valid = 0, dp_out = 0.
  - candidates = 4'hF, stab_cnt = 0, seen = 0.
  - frame_done = 0, sel_err = 0.
- First strobe after reset release is processed normally.

## Configuration
- SEG7_DP_EN defined:
  - scan_seg is 8 bits; bit 7 is the decimal point.
  - The dp bit is part of the candidate compare: a dp change alone restarts stability.
  - dp_out[i] commits together with nibble i.
- SEG7_DP_EN undefined:
  - scan_seg is 7 bits.
  - The dp_out port and dp state are absent.

## Test plan
- Reset: assert rst mid-frame with digits committed → next cycle bcd_out = 24'hFFFFFF, digit_valid = 0, no pulses.
- Stability: STABLE_COUNT = 2, digit 0 strobed with 1011011, 1111001, 1111001 → no commit after strobes 1–2; after strobe 3, nibble 0 = 3 and digit_valid[0] = 1.
- Invalid pattern: digit 2 strobed twice with 0000000 after holding 7 → nibble 2 = 4'hF and digit_valid[2] = 0.
- Frame: NUM_DIGITS = 6, strobe sel 000001…100000 once each → frame_done is high exactly one cycle after the sixth strobe. Repeating digit 5 first does not pulse until all six are seen again.
- Select error: strobe with scan_sel = 000011 → sel_err pulses once and bcd_out is unchanged. scan_sel = 000000 gives the same result.
- DP (SEG7_DP_EN): digit 1 = 8 committed with dp = 0, then two strobes of 11111111 → dp_out[1] = 1 after the second strobe, and nibble 1 stays 8.
